uvma_apb4_mem_completer: RTL and testbench

// - Synthesizable APB4 completer (slave) backed by a byte-enabled word memory.
// - Successor to the APB3 signal set: adds PSTRB and PPROT, parametrised widths and depth.
// - Adds programmable wait states and a privileged-write region; errors are reported on PSLVERR.
// - Used as a DUT-side responder in agent self-tests and as a scratch memory behind APB fabrics.

---
 rtl/uvma_apb4_pkg.sv | 10 +
 rtl/uvma_apb4_mem_bank.sv | 24 ++
 rtl/uvma_apb4_mem_completer.sv | 82 ++++++++
 tb/tb_uvma_apb4_mem_completer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uvma_apb4_pkg.sv
// uvma_apb4_pkg: shared state enum, PPROT bit positions and strobe-width helper for the APB4 completer
package uvma_apb4_pkg;
  typedef enum logic {IDLE, ACCESS} apb4_cmp_state_e;
  localparam int PPROT_PRIV_BIT = 0;
  localparam int PPROT_NSEC_BIT = 1;
  localparam int PPROT_INSTR_BIT = 2;
  function automatic int apb4_strb_w(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/uvma_apb4_mem_bank.sv
// uvma_apb4_mem_bank: DEPTH x DATA_WIDTH word array with per-byte write enables and a registered read port
module uvma_apb4_mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int SW = DATA_WIDTH / 8,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IW-1:0]         i_widx,
  input  logic [SW-1:0]         i_wstrb,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [IW-1:0]         i_ridx,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we)
      for (int b = 0; b < SW; b++)
        if (i_wstrb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_re) o_rdata <= r_mem[i_ridx];
  end
endmodule

// File: rtl/uvma_apb4_mem_completer.sv
// uvma_apb4_mem_completer: APB4 completer with programmable wait states, privileged-write region
// and error decode, backed by a byte-enabled word memory.
module uvma_apb4_mem_completer
  import uvma_apb4_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 0,
  parameter int PRIV_BASE = 'h800
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               psel,
  input  logic                               penable,
  input  logic                               pwrite,
  input  logic [ADDR_WIDTH-1:0]              paddr,
  input  logic [DATA_WIDTH-1:0]              pwdata,
  input  logic [apb4_strb_w(DATA_WIDTH)-1:0] pstrb,
  input  logic [2:0]                         pprot,
  output logic                               pready,
  output logic [DATA_WIDTH-1:0]              prdata,
  output logic                               pslverr
);
  localparam int SW = apb4_strb_w(DATA_WIDTH);
  localparam int ALIGN = $clog2(SW);
  localparam int IW = $clog2(DEPTH);
  apb4_cmp_state_e       r_state;
  logic [3:0]            r_cnt;
  logic                  r_write, r_err, r_rvalid;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_strb;
  logic                  w_setup, w_err, w_re, w_we, w_unused;
  logic [IW-1:0]         w_idx, w_ridx;
  logic [DATA_WIDTH-1:0] w_rdata;
  assign w_unused = &{1'b0, pprot[PPROT_NSEC_BIT], pprot[PPROT_INSTR_BIT]};
  assign w_setup = (r_state == IDLE) && psel && !penable;
  assign w_idx = IW'(paddr >> ALIGN);
  assign w_err = ((paddr & ADDR_WIDTH'(SW - 1)) != '0) ||
                 ((32'(paddr) >> ALIGN) >= 32'(DEPTH)) ||
                 (pwrite && (32'(paddr) >= 32'(PRIV_BASE)) && !pprot[PPROT_PRIV_BIT]);
  assign pready = (r_state == ACCESS) && (r_cnt == '0);
  assign pslverr = pready && r_err;
  assign prdata = r_rvalid ? w_rdata : '0;
  // The read is launched one edge early so the registered port lines up with the completing cycle.
  assign w_re = !reset && ((w_setup && !pwrite && !w_err && WAIT_STATES == 0) ||
                (r_state == ACCESS && psel && r_cnt == 4'd1 && !r_write && !r_err));
  assign w_ridx = (r_state == IDLE) ? w_idx : r_idx;
  assign w_we = !reset && pready && psel && r_write && !r_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_re;
      if (r_state == IDLE) begin
        if (w_setup) begin
          r_state <= ACCESS;
          r_cnt <= 4'(WAIT_STATES);
          r_write <= pwrite;
          r_idx <= w_idx;
          r_wdata <= pwdata;
          r_strb <= pstrb;
          r_err <= w_err;
        end
      end else if (!psel || r_cnt == '0) r_state <= IDLE;
      else r_cnt <= r_cnt - 4'd1;
    end
  end
  uvma_apb4_mem_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_bank (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (r_idx),
    .i_wstrb (r_strb),
    .i_wdata (r_wdata),
    .i_re    (w_re),
    .i_ridx  (w_ridx),
    .o_rdata (w_rdata)
  );
endmodule

// File: tb/tb_uvma_apb4_mem_completer.sv
// tb_uvma_apb4_mem_completer: directed bench on two completers, one with no wait states (DEPTH=1024)
// and one with three wait states (DEPTH=256), sharing all bus inputs except psel.
module tb_uvma_apb4_mem_completer;
  logic clk = 0, reset = 0, psel0 = 0, psel3 = 0, penable = 0, pwrite = 0;
  logic [11:0] paddr = 0;
  logic [31:0] pwdata = 0;
  logic [3:0] pstrb = 0;
  logic [2:0] pprot = 0;
  logic pready0, pslverr0, pready3, pslverr3;
  logic [31:0] prdata0, prdata3;
  int nchk = 0, nfail = 0;
  always #5 clk = ~clk;
  uvma_apb4_mem_completer #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .psel(psel0), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0));
  uvma_apb4_mem_completer #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .psel(psel3), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pready(pready3), .prdata(prdata3), .pslverr(pslverr3));

  task automatic xfer(input bit s3, input bit wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] st, input logic [2:0] p,
                      output logic [31:0] rd, output logic er, output int waits);
    @(negedge clk);
    psel0 = !s3; psel3 = s3; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = st; pprot = p;
    @(negedge clk);
    penable = 1;
    waits = 0;
    while (!(s3 ? pready3 : pready0) && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    rd = s3 ? prdata3 : prdata0;
    er = s3 ? pslverr3 : pslverr0;
    nchk++;
    if (!(s3 ? pready3 : pready0)) begin
      nfail++;
      $display("FAIL xfer_timeout addr=%h: pready never rose within %0d cycles", a, waits);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    psel0 = 0; psel3 = 0; penable = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    nchk++;
    if ({pready0, pslverr0, prdata0} !== 33'd0) begin
      nfail++; $display("FAIL reset_dut0: got %b/%b/%h expected 0/0/0", pready0, pslverr0, prdata0);
    end
    nchk++;
    if ({pready3, pslverr3, prdata3} !== 33'd0) begin
      nfail++; $display("FAIL reset_dut3: got %b/%b/%h expected 0/0/0", pready3, pslverr3, prdata3);
    end
    reset = 0;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int w;
    xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 3'd0, rd, er, w);
    nchk++;
    if (w !== 0 || er !== 1'b0) begin
      nfail++; $display("FAIL basic_write: waits=%0d err=%b expected 0/0", w, er);
    end
    xfer(0, 0, 12'h010, 32'h0, 4'h0, 3'd0, rd, er, w);
    nchk++;
    if (w !== 0 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      nfail++; $display("FAIL basic_read: waits=%0d err=%b data=%h expected 0/0/deadbeef", w, er, rd);
    end
    idle();
    nchk++;
    if (prdata0 !== 32'd0) begin
      nfail++; $display("FAIL prdata_clear: got %h expected 0", prdata0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int w;
    xfer(0, 1, 12'h020, 32'h11223344, 4'hF, 3'd0, rd, er, w);
    xfer(0, 1, 12'h020, 32'hAABBCCDD, 4'b0101, 3'd0, rd, er, w);
    xfer(0, 0, 12'h020, 32'h0, 4'h0, 3'd0, rd, er, w);
    nchk++;
    if (rd !== 32'h11BB33DD || er !== 1'b0) begin
      nfail++; $display("FAIL strobe_merge: data=%h err=%b expected 11bb33dd/0", rd, er);
    end
    xfer(0, 1, 12'h020, 32'h00000000, 4'h0, 3'd0, rd, er, w);
    nchk++;
    if (er !== 1'b0) begin
      nfail++; $display("FAIL zero_strobe_err: got %b expected 0", er);
    end
    xfer(0, 0, 12'h020, 32'h0, 4'h0, 3'd0, rd, er, w);
    nchk++;
    if (rd !== 32'h11BB33DD) begin
      nfail++; $display("FAIL zero_strobe_data: got %h expected 11bb33dd", rd);
    end
    idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int w;
    xfer(1, 1, 12'h010, 32'h5A5A1234, 4'hF, 3'd0, rd, er, w);
    nchk++;
    if (w !== 3 || er !== 1'b0) begin
      nfail++; $display("FAIL ws_write: waits=%0d err=%b expected 3/0", w, er);
    end
    xfer(1, 0, 12'h010, 32'h0, 4'h0, 3'd0, rd, er, w);
    nchk++;
    if (w !== 3 || rd !== 32'h5A5A1234 || er !== 1'b0) begin
      nfail++; $display("FAIL ws_read: waits=%0d data=%h err=%b expected 3/5a5a1234/0", w, rd, er);
    end
    idle();
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int w;
    xfer(0, 0, 12'h402, 32'h0, 4'h0, 3'd0, rd, er, w);
    nchk++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      nfail++; $display("FAIL misaligned: err=%b data=%h expected 1/0", er, rd);
    end
    idle();
    xfer(1, 0, 12'h400, 32'h0, 4'h0, 3'd0, rd, er, w);
    nchk++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      nfail++; $display("FAIL out_of_range: err=%b data=%h expected 1/0", er, rd);
    end
    idle();
    xfer(0, 1, 12'h800, 32'h12345678, 4'hF, 3'd1, rd, er, w);
    nchk++;
    if (er !== 1'b0) begin
      nfail++; $display("FAIL priv_write_ok: err=%b expected 0", er);
    end
    xfer(0, 1, 12'h800, 32'hFFFFFFFF, 4'hF, 3'd0, rd, er, w);
    nchk++;
    if (er !== 1'b1) begin
      nfail++; $display("FAIL priv_violation: err=%b expected 1", er);
    end
    xfer(0, 0, 12'h800, 32'h0, 4'h0, 3'd1, rd, er, w);
    nchk++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      nfail++; $display("FAIL priv_readback: data=%h err=%b expected 12345678/0", rd, er);
    end
    idle();
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int w; int seen;
    xfer(1, 1, 12'h030, 32'hCAFEF00D, 4'hF, 3'd0, rd, er, w);
    idle();
    @(negedge clk);
    psel3 = 1; penable = 0; pwrite = 1; paddr = 12'h030; pwdata = 32'h0; pstrb = 4'hF;
    @(negedge clk);
    penable = 1;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0; psel3 = 0; penable = 0;
    nchk++;
    if ({pready3, pslverr3, prdata3} !== 33'd0) begin
      nfail++; $display("FAIL reset_mid_outputs: got %b/%b/%h expected 0/0/0", pready3, pslverr3, prdata3);
    end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (pready3) seen++;
    end
    nchk++;
    if (seen !== 0) begin
      nfail++; $display("FAIL reset_mid_pready: pready seen %0d cycles expected 0", seen);
    end
    xfer(1, 0, 12'h030, 32'h0, 4'h0, 3'd0, rd, er, w);
    nchk++;
    if (rd !== 32'hCAFEF00D) begin
      nfail++; $display("FAIL reset_mid_data: got %h expected cafef00d", rd);
    end
    idle();
  endtask

  task automatic test_stray_abort();
    logic [31:0] rd; logic er; int w; int seen;
    @(negedge clk);
    psel0 = 1; penable = 1; pwrite = 0; paddr = 12'h010;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (pready0) seen++;
    end
    nchk++;
    if (seen !== 0) begin
      nfail++; $display("FAIL stray_penable: pready seen %0d cycles expected 0", seen);
    end
    idle();
    xfer(1, 1, 12'h040, 32'h0BADF00D, 4'hF, 3'd0, rd, er, w);
    idle();
    @(negedge clk);
    psel3 = 1; penable = 0; pwrite = 1; paddr = 12'h040; pwdata = 32'h77777777; pstrb = 4'hF;
    @(negedge clk);
    penable = 1;
    @(negedge clk);
    psel3 = 0; penable = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (pready3) seen++;
    end
    nchk++;
    if (seen !== 0) begin
      nfail++; $display("FAIL abort_pready: pready seen %0d cycles expected 0", seen);
    end
    xfer(1, 0, 12'h040, 32'h0, 4'h0, 3'd0, rd, er, w);
    nchk++;
    if (rd !== 32'h0BADF00D || w !== 3 || er !== 1'b0) begin
      nfail++; $display("FAIL abort_next: data=%h waits=%0d err=%b expected 0badf00d/3/0", rd, w, er);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_reset_mid_access();
    test_stray_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
